// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the datapath and mul_div_unit.
// The op_unsigned signal exists only when MULDIV_UNSIGNED_EN is defined.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
`ifdef MULDIV_UNSIGNED_EN
    logic             op_unsigned;
`endif
    logic [WIDTH-1:0] Y_in;
    logic [WIDTH-1:0] Bus_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;

    modport master (
`ifdef MULDIV_UNSIGNED_EN
        output op_unsigned,
`endif
        output start, op_div, Y_in, Bus_in,
        input  busy, done, div_by_zero, z_hi, z_lo
    );

    modport slave (
`ifdef MULDIV_UNSIGNED_EN
        input  op_unsigned,
`endif
        input  start, op_div, Y_in, Bus_in,
        output busy, done, div_by_zero, z_hi, z_lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: fixed-latency signed multiply (radix-2 Booth) / restoring divide engine.
// Defining MULDIV_UNSIGNED_EN adds op_unsigned for unsigned multiply/divide.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           clear,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             div_r;
    logic             uns_r;
    logic [WIDTH:0]   hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             bq_r;
    logic [WIDTH:0]   m_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] z_hi_r;
    logic [WIDTH-1:0] z_lo_r;

    logic             uns_in_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             b_zero_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   hi_nx_s;
    logic [WIDTH-1:0] lo_nx_s;
    logic             bq_nx_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

`ifdef MULDIV_UNSIGNED_EN
    assign uns_in_s = bus.op_unsigned;
`else
    assign uns_in_s = 1'b0;
`endif

    assign a_neg_s  = ~uns_r & a_r[WIDTH-1];
    assign b_neg_s  = ~uns_r & b_r[WIDTH-1];
    assign b_zero_s = (b_r == {WIDTH{1'b0}});

    // One multiply or divide step on the shared hi/lo accumulator.
    always_comb begin
        sum_s     = hi_r;
        shifted_s = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
        diff_s    = shifted_s - m_r;
        hi_nx_s   = hi_r;
        lo_nx_s   = lo_r;
        bq_nx_s   = bq_r;
        if (div_r) begin
            // Sign bit of the trial difference decides restore vs keep.
            if (diff_s[WIDTH]) begin
                hi_nx_s = shifted_s;
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_nx_s = diff_s;
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (uns_r) begin
                sum_s   = lo_r[0] ? (hi_r + m_r) : hi_r;
                hi_nx_s = {1'b0, sum_s[WIDTH:1]};
            end else begin
                case ({lo_r[0], bq_r})
                    2'b01:   sum_s = hi_r + m_r;
                    2'b10:   sum_s = hi_r - m_r;
                    default: sum_s = hi_r;
                endcase
                hi_nx_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
            end
            lo_nx_s = {sum_s[0], lo_r[WIDTH-1:1]};
            bq_nx_s = lo_r[0];
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            div_r   <= 1'b0;
            uns_r   <= 1'b0;
            hi_r    <= {(WIDTH+1){1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            bq_r    <= 1'b0;
            m_r     <= {(WIDTH+1){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            z_hi_r  <= {WIDTH{1'b0}};
            z_lo_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.Y_in;
                        b_r     <= bus.Bus_in;
                        div_r   <= bus.op_div;
                        uns_r   <= uns_in_s;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        dbz_r   <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    // Count 0 prepares operands so magnitude logic stays off the bus path.
                    if (cnt_r == {CW{1'b0}}) begin
                        hi_r <= {(WIDTH+1){1'b0}};
                        bq_r <= 1'b0;
                        if (div_r) begin
                            lo_r <= a_neg_s ? negate(a_r) : a_r;
                            m_r  <= {1'b0, (b_neg_s ? negate(b_r) : b_r)};
                        end else begin
                            lo_r <= b_r;
                            m_r  <= uns_r ? {1'b0, a_r} : {a_r[WIDTH-1], a_r};
                        end
                    end else begin
                        hi_r <= hi_nx_s;
                        lo_r <= lo_nx_s;
                        bq_r <= bq_nx_s;
                        if (cnt_r == LAST_ITER) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                FIX: begin
                    if (!div_r) begin
                        z_hi_r <= hi_r[WIDTH-1:0];
                        z_lo_r <= lo_r;
                    end else if (b_zero_s) begin
                        z_hi_r <= a_r;
                        z_lo_r <= {WIDTH{1'b1}};
                        dbz_r  <= 1'b1;
                    end else begin
                        z_hi_r <= a_neg_s ? negate(hi_r[WIDTH-1:0]) : hi_r[WIDTH-1:0];
                        z_lo_r <= (a_neg_s ^ b_neg_s) ? negate(lo_r) : lo_r;
                    end
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.z_hi        = z_hi_r;
    assign bus.z_lo        = z_lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized scoreboard bench for mul_div_unit against a longint arithmetic model.
// Exercises MULDIV_UNSIGNED_EN paths when that macro is defined.
module tb_mul_div_unit;
    localparam int W = 32;
    localparam int LAT = 35;  // cycle-counter distance from issue negedge to done negedge

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           issue_cyc;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   run_len = 0;
    int   last_run = 0;
    exp_t sb_q[$];

    mul_div_unit_if #(.WIDTH(W)) bus_if ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic div, input logic uns);
        exp_t            e;
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.dbz = 1'b0;
        e.issue_cyc = 0;
        if (!div) begin
            if (uns) ur = ua * ub;
            else ur = sa * sb;
            e.hi = ur[63:32];
            e.lo = ur[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else if (uns) begin
            ur = ua / ub;
            e.lo = ur[31:0];
            ur = ua % ub;
            e.hi = ur[31:0];
        end else begin
            sr = sa / sb;
            e.lo = sr[31:0];
            sr = sa % sb;
            e.hi = sr[31:0];
        end
        return e;
    endfunction

    // Issue one accepted request and push its expected result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic div,
                          input logic uns, output exp_t e);
        int   n;
        logic uns_eff;
`ifdef MULDIV_UNSIGNED_EN
        uns_eff = uns;
`else
        uns_eff = 1'b0;
`endif
        @(negedge clock);
        n = 0;
        while ((bus_if.busy || bus_if.done) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
        bus_if.start = 1'b1;
        bus_if.op_div = div;
        bus_if.Y_in = a;
        bus_if.Bus_in = b;
`ifdef MULDIV_UNSIGNED_EN
        bus_if.op_unsigned = uns_eff;
`endif
        e = model(a, b, div, uns_eff);
        e.issue_cyc = cyc;
        sb_q.push_back(e);
        @(negedge clock);
        bus_if.start = 1'b0;
        bus_if.Y_in = $urandom;
        bus_if.Bus_in = $urandom;
        bus_if.op_div = ~div;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_z_hi"}, 64'(bus_if.z_hi), 64'd0);
        chk({tag, "_z_lo"}, 64'(bus_if.z_lo), 64'd0);
        chk({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus_if.done), 64'd0);
        chk({tag, "_dbz"}, 64'(bus_if.div_by_zero), 64'd0);
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        if (bus_if.busy) run_len++;
        else begin
            last_run = run_len;
            run_len = 0;
        end
        if (bus_if.done) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_done: done=1 with no accepted request pending");
            end else begin
                e = sb_q.pop_front();
                chk("z_hi", 64'(bus_if.z_hi), 64'(e.hi));
                chk("z_lo", 64'(bus_if.z_lo), 64'(e.lo));
                chk("div_by_zero", 64'(bus_if.div_by_zero), 64'(e.dbz));
                chk("latency", 64'(cyc - e.issue_cyc), 64'(LAT));
                chk("busy_cycles", 64'(last_run), 64'd34);
            end
        end
    end

    initial begin
        exp_t e;
        exp_t e2;
        int   n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus_if.start = 1'b0;
        bus_if.op_div = 1'b0;
        bus_if.Y_in = '0;
        bus_if.Bus_in = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus_if.op_unsigned = 1'b0;
`endif
        repeat (2) @(negedge clock);
        clear = 1'b0;
        chk_zero_state("reset");

        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, e);
        drain();
        chk("mul_m3x7_hi", 64'(bus_if.z_hi), 64'h0000_0000_FFFF_FFFF);
        chk("mul_m3x7_lo", 64'(bus_if.z_lo), 64'h0000_0000_FFFF_FFEB);

        run_op(32'hFFFF_FFEF, 32'd5, 1'b1, 1'b0, e);
        drain();
        chk("div_m17_5_q", 64'(bus_if.z_lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_m17_5_r", 64'(bus_if.z_hi), 64'h0000_0000_FFFF_FFFE);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, e);
        drain();
        chk("div_min_m1_q", 64'(bus_if.z_lo), 64'h0000_0000_8000_0000);

        run_op(32'd1234, 32'd0, 1'b1, 1'b0, e);
        drain();
        chk("dbz_r", 64'(bus_if.z_hi), 64'd1234);
        run_op(32'd1234, 32'd2, 1'b1, 1'b0, e);
        chk("dbz_cleared_on_start", 64'(bus_if.div_by_zero), 64'd0);
        drain();

        // Start pulsed during busy cycle 10 must be ignored.
        run_op(32'd100000, 32'hFFFF_FF9C, 1'b0, 1'b0, e);
        repeat (9) @(negedge clock);
        bus_if.start = 1'b1;
        bus_if.Y_in = 32'd5;
        bus_if.Bus_in = 32'd5;
        @(negedge clock);
        bus_if.start = 1'b0;
        drain();
        repeat (40) @(negedge clock);
        chk("busy_start_keep_lo", 64'(bus_if.z_lo), 64'(e.lo));

        // Start during the done cycle must be ignored.
        run_op(32'd77, 32'd3, 1'b1, 1'b0, e);
        n = 0;
        while (!bus_if.done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("done_wait_timeout", 64'd1, 64'd0);
        bus_if.start = 1'b1;
        bus_if.op_div = 1'b0;
        bus_if.Y_in = 32'd9;
        bus_if.Bus_in = 32'd9;
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (40) @(negedge clock);
        chk("done_start_busy", 64'(bus_if.busy), 64'd0);
        chk("done_start_keep_lo", 64'(bus_if.z_lo), 64'(e.lo));

`ifdef MULDIV_UNSIGNED_EN
        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, e);
        drain();
        chk("umul_hi", 64'(bus_if.z_hi), 64'd1);
        chk("umul_lo", 64'(bus_if.z_lo), 64'h0000_0000_FFFF_FFFE);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, e);
        drain();
        chk("smul_hi", 64'(bus_if.z_hi), 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: begin a = 32'h8000_0000; b = $urandom; end
                3: b = $urandom_range(1, 100);
                4: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e2);
            drain();
        end

        // Clear at RUN cycle 20 kills the operation with no done.
        run_op(32'h1234_5678, 32'h0000_0FFF, 1'b0, 1'b0, e);
        repeat (19) @(negedge clock);
        clear = 1'b1;
        sb_q.delete();
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        chk_zero_state("midrun_clear");
        repeat (40) @(negedge clock);
        chk("midrun_clear_lo_stays", 64'(bus_if.z_lo), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
